// File: rtl/mil_1553_txd_if.sv
// MIL-STD-1553 transmitter handshake and line bundle.
// Host side loads words; the transmitter drives the line pair.
interface mil_1553_txd_if;
    logic        tx_start;
    logic        tx_cw;
    logic [15:0] tx_data;
    logic        tx_ready;
    logic        tx_busy;
    logic        tx_done;
    logic        TXP;
    logic        TXN;

    modport master (
        output tx_start, tx_cw, tx_data,
        input  tx_ready, tx_busy, tx_done, TXP, TXN
    );

    modport slave (
        input  tx_start, tx_cw, tx_data,
        output tx_ready, tx_busy, tx_done, TXP, TXN
    );
endinterface

// File: rtl/mil_1553_txd.sv
// MIL-STD-1553 Manchester-II word transmitter with a one-word holding buffer.
// Line outputs are registered one clk behind the shifter state.
module mil_1553_txd #(
    parameter int HALF_BIT = 25,
    parameter int GAP_CLK  = 200
) (
    input logic           clk,
    input logic           rst,
    mil_1553_txd_if.slave bus
);
    localparam int HW = $clog2(3 * HALF_BIT);
    localparam int GW = $clog2(GAP_CLK + 1);

    typedef enum logic [2:0] {
        IDLE, SYNC, DATA, PAR, GAP
    } state_t;

    state_t          state_q;
    logic [HW-1:0]   hcnt_q;
    logic            half_q;
    logic [4:0]      bit_q;
    logic [GW-1:0]   gcnt_q;
    logic [15:0]     sh_q;
    logic            cw_q;
    logic            par_q;
    logic            full_q;
    logic [15:0]     buf_q;
    logic            bcw_q;
    logic            txp_q;
    logic            txn_q;
    logic            busy_q;
    logic            done_q;

    logic half_last;
    logic bit_end;
    logic par_end;
    logic launch;
    logic lvl;
    logic active;
    logic txp_d;
    logic txn_d;
    logic done_d;

    always_comb begin
        half_last = 1'b0;
        lvl       = 1'b0;
        unique case (state_q)
            SYNC: begin
                half_last = hcnt_q == HW'(3 * HALF_BIT - 1);
                lvl       = cw_q ^ half_q;
            end
            DATA: begin
                half_last = hcnt_q == HW'(HALF_BIT - 1);
                lvl       = sh_q[15] ^ half_q;
            end
            PAR: begin
                half_last = hcnt_q == HW'(HALF_BIT - 1);
                lvl       = par_q ^ half_q;
            end
            default: begin
                half_last = 1'b0;
                lvl       = 1'b0;
            end
        endcase
        bit_end = half_last && half_q;
        par_end = (state_q == PAR) && bit_end;
        launch  = full_q && ((state_q == IDLE) || par_end);
        active  = state_q inside {SYNC, DATA, PAR};
        txp_d   = active && lvl;
        txn_d   = active && !lvl;
        done_d  = par_end;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            half_q  <= 1'b0;
            bit_q   <= '0;
            gcnt_q  <= '0;
            sh_q    <= '0;
            cw_q    <= 1'b0;
            par_q   <= 1'b0;
            full_q  <= 1'b0;
            buf_q   <= '0;
            bcw_q   <= 1'b0;
            txp_q   <= 1'b0;
            txn_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            txp_q  <= txp_d;
            txn_q  <= txn_d;
            done_q <= done_d;
            busy_q <= state_q != IDLE;

            if (bus.tx_start && !full_q) begin
                full_q <= 1'b1;
                buf_q  <= bus.tx_data;
                bcw_q  <= bus.tx_cw;
            end

            if (launch) begin
                // Buffer moves into the shifter; next sync starts at once
                state_q <= SYNC;
                sh_q    <= buf_q;
                cw_q    <= bcw_q;
                par_q   <= ~^buf_q;
                full_q  <= 1'b0;
                hcnt_q  <= '0;
                half_q  <= 1'b0;
                bit_q   <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        hcnt_q <= '0;
                    end
                    SYNC: begin
                        if (half_last) begin
                            hcnt_q <= '0;
                            half_q <= ~half_q;
                            if (half_q) begin
                                state_q <= DATA;
                                bit_q   <= '0;
                            end
                        end else begin
                            hcnt_q <= hcnt_q + HW'(1);
                        end
                    end
                    DATA: begin
                        if (half_last) begin
                            hcnt_q <= '0;
                            half_q <= ~half_q;
                            if (half_q) begin
                                sh_q <= {sh_q[14:0], 1'b0};
                                if (bit_q == 5'd15) begin
                                    state_q <= PAR;
                                    bit_q   <= 5'd16;
                                end else begin
                                    bit_q <= bit_q + 5'd1;
                                end
                            end
                        end else begin
                            hcnt_q <= hcnt_q + HW'(1);
                        end
                    end
                    PAR: begin
                        if (half_last) begin
                            hcnt_q <= '0;
                            half_q <= ~half_q;
                            if (half_q) begin
                                state_q <= GAP;
                                gcnt_q  <= '0;
                            end
                        end else begin
                            hcnt_q <= hcnt_q + HW'(1);
                        end
                    end
                    GAP: begin
                        if (gcnt_q == GW'(GAP_CLK - 1)) begin
                            state_q <= IDLE;
                            gcnt_q  <= '0;
                        end else begin
                            gcnt_q <= gcnt_q + GW'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.tx_ready = ~full_q;
    assign bus.tx_busy  = busy_q;
    assign bus.tx_done  = done_q;
    assign bus.TXP      = txp_q;
    assign bus.TXN      = txn_q;
endmodule
